// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
// Holds the operation encoding seen on the op port, the control FSM
// state encoding and small decode helpers used by RTL and bench alike.
package hilo_pkg;

    localparam logic [2:0] OP_MTHI  = 3'd0;
    localparam logic [2:0] OP_MTLO  = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_MULTU = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } hilo_state_e;

    // Encodings 6 and 7 are reserved and never accepted.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

    // MULT and DIV treat operands as two's complement; the U variants do not.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: issue/result bundle between the EX stage and the
// HI/LO unit.
//   start, op, rs, rt, flush : issue side, driven by the pipeline (master)
//   busy, done, div_zero     : status, driven by the unit (slave)
//   hi, lo                   : architectural HI/LO registers
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/div_iter_core.sv
// div_iter_core: unsigned restoring shift-subtract divider, one quotient
// bit per clock.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_load        : capture dividend/divisor and restart
//   i_dividend    : unsigned dividend
//   i_divisor     : unsigned divisor (non-zero; zero is handled by the caller)
//   o_quotient    : quotient, meaningful once o_valid is high
//   o_remainder   : remainder, meaningful once o_valid is high
//   o_valid       : high from WIDTH cycles after load until the next load
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_valid
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_rem_nxt;

    // One restoring step: shift next dividend bit into the partial remainder
    // and keep the subtraction only if it did not borrow.
    always_comb begin
        w_trial = {r_rem, r_q[WIDTH-1]} - {1'b0, r_div};
        if (!w_trial[WIDTH]) begin
            w_rem_nxt = w_trial[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nxt = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration state: the quotient shifts in where the dividend shifts out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= {WIDTH{1'b0}};
            r_rem   <= {WIDTH{1'b0}};
            r_div   <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_dividend;
            r_rem   <= {WIDTH{1'b0}};
            r_div   <= i_divisor;
            r_cnt   <= CNT_W'(WIDTH);
            r_valid <= 1'b0;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_q     <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= r_cnt - CNT_W'(1);
            r_valid <= (r_cnt == CNT_W'(1));
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_quotient  = r_q;
    assign o_remainder = r_rem;
    assign o_valid     = r_valid;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MIPS HI/LO unit. Executes MTHI/MTLO, MULT/MULTU and
// DIV/DIVU, and owns the architectural HI and LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hilo_muldiv_unit_if (start/op/rs/rt/flush in,
//                busy/done/div_zero/hi/lo out, all outputs registered)
// Multiply holds busy for MUL_CYCLES cycles and writes the product at the
// last busy edge. Divide runs WIDTH iterations on magnitudes and then one
// FIX cycle that restores signs and writes lo=quotient, hi=remainder.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    hilo_muldiv_unit_if.slave bus
);

    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    hilo_state_e        r_state;
    hilo_state_e        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_busy;
    logic               r_dz;
    logic               w_dz_nxt;
    logic               w_load_div;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz_path;

    logic               w_accept;
    logic               w_op_signed;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_core_q;
    logic [WIDTH-1:0]   w_core_r;
    logic               w_core_valid;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // A flush in the issue cycle kills the request before it is accepted.
    assign w_accept    = bus.start && (r_state == S_IDLE) && op_is_valid(bus.op)
                         && !bus.flush;
    assign w_op_signed = op_is_signed(bus.op);

    // Magnitudes feed the unsigned core; MIN maps onto itself, which is its
    // correct unsigned magnitude.
    assign w_dvd_mag = (w_op_signed && bus.rs[WIDTH-1]) ? (~bus.rs + WIDTH'(1)) : bus.rs;
    assign w_dvs_mag = (w_op_signed && bus.rt[WIDTH-1]) ? (~bus.rt + WIDTH'(1)) : bus.rt;

    // Sign- or zero-extend to full width so the low 2*WIDTH bits of the
    // product are right for both MULT and MULTU.
    assign w_a_ext = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_q_fix = r_neg_q ? (~w_core_q + WIDTH'(1)) : w_core_q;
    assign w_r_fix = r_neg_r ? (~w_core_r + WIDTH'(1)) : w_core_r;

    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_div_iter_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load_div),
        .i_dividend  (w_dvd_mag),
        .i_divisor   (w_dvs_mag),
        .o_quotient  (w_core_q),
        .o_remainder (w_core_r),
        .o_valid     (w_core_valid)
    );

    // Next-state and next-output decode for the control FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = r_dz;
        w_load_div  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dz_nxt = 1'b0;
                    case (bus.op)
                        OP_MTHI: begin
                            w_hi_nxt   = bus.rs;
                            w_done_nxt = 1'b1;
                        end
                        OP_MTLO: begin
                            w_lo_nxt   = bus.rs;
                            w_done_nxt = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            w_state_nxt = S_MUL;
                            w_cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor skips iteration and goes straight to FIX.
                            if (bus.rt == {WIDTH{1'b0}}) begin
                                w_state_nxt = S_FIX;
                            end else begin
                                w_state_nxt = S_DIV;
                                w_cnt_nxt   = CNT_W'(WIDTH - 1);
                                w_load_div  = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt          = S_IDLE;
                    {w_hi_nxt, w_lo_nxt} = w_prod;
                    w_done_nxt           = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = S_FIX;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    if (r_dz_path) begin
                        w_lo_nxt = {WIDTH{1'b1}};
                        w_hi_nxt = r_a;
                        w_dz_nxt = 1'b1;
                    end else if (w_core_valid) begin
                        w_lo_nxt = w_q_fix;
                        w_hi_nxt = w_r_fix;
                    end else begin
                        w_lo_nxt = r_lo;
                        w_hi_nxt = r_hi;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, counter and architectural/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_dz    <= w_dz_nxt;
        end
    end

    // Operand capture and sign bookkeeping at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz_path <= 1'b0;
        end else if (w_accept) begin
            r_a       <= bus.rs;
            r_b       <= bus.rt;
            r_signed  <= w_op_signed;
            r_neg_q   <= w_op_signed & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
            r_neg_r   <= w_op_signed & bus.rs[WIDTH-1];
            r_dz_path <= (bus.rt == {WIDTH{1'b0}});
        end else begin
            r_a       <= r_a;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_dz;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench for hilo_muldiv_unit. The stimulus
// process pushes the expected {hi, lo, div_zero, done cycle} for each
// accepted op; a negedge monitor pops and compares whenever done is high
// and checks busy every cycle against the expected busy window.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W  = 32;
    localparam int MC = 4;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc       = 0;
    int           checks    = 0;
    int           errors    = 0;
    int           busy_from = 0;
    int           busy_to   = -1;
    logic [W-1:0] m_hi      = '0;
    logic [W-1:0] m_lo      = '0;
    logic         m_dz      = 1'b0;
    logic [W-1:0] p_hi;
    logic [W-1:0] p_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: busy window every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", W'(bus.busy), W'((cyc >= busy_from) && (cyc <= busy_to)));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", W'(cyc), W'(mon_e.cyc));
                    check("hi", bus.hi, mon_e.hi);
                    check("lo", bus.lo, mon_e.lo);
                    check("div_zero", W'(bus.div_zero), W'(mon_e.dz));
                end
            end
        end
    end

    // Reference model: architectural effect and latency straight from the op rules.
    task automatic apply_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat);
        logic signed [2*W-1:0] sa, sbv, sq, sr;
        logic [2*W-1:0] ua, ub, p;
        m_dz = 1'b0;
        lat  = 1;
        case (op)
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            OP_MULT: begin
                sa = $signed(a); sbv = $signed(b);
                p  = sa * sbv;
                {m_hi, m_lo} = p;
                lat = MC + 1;
            end
            OP_MULTU: begin
                ua = {{W{1'b0}}, a}; ub = {{W{1'b0}}, b};
                p  = ua * ub;
                {m_hi, m_lo} = p;
                lat = MC + 1;
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    m_lo = '1; m_hi = a; m_dz = 1'b1; lat = 2;
                end else if (op == OP_DIV) begin
                    sa = $signed(a); sbv = $signed(b);
                    sq = sa / sbv; sr = sa % sbv;
                    m_lo = sq[W-1:0]; m_hi = sr[W-1:0]; lat = W + 2;
                end else begin
                    ua = {{W{1'b0}}, a}; ub = {{W{1'b0}}, b};
                    p = ua / ub; m_lo = p[W-1:0];
                    p = ua % ub; m_hi = p[W-1:0];
                    lat = W + 2;
                end
            end
            default: lat = 1;
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // Drive one start cycle; push the expectation if the op is a real one.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        int   c;
        exp_t e;
        c    = cyc;
        p_hi = m_hi;
        p_lo = m_lo;
        bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
        if (op_is_valid(op)) begin
            apply_model(op, a, b, lat);
            e.hi = m_hi; e.lo = m_lo; e.dz = m_dz; e.cyc = c + lat;
            sb.push_back(e);
            busy_from = c + 1;
            busy_to   = c + lat - 1;
        end else begin
            lat = 1;
        end
        step();
        bus.start = 1'b0;
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int c, lat;
        c = cyc;
        issue(op, a, b, lat);
        wait_until(c + lat);
    endtask

    // Drop the in-flight expectation; an accepted start still cleared div_zero.
    task automatic abort();
        m_hi = p_hi; m_lo = p_lo; m_dz = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
    endtask

    initial begin
        int c, lat;
        logic [2:0]   op_r;
        logic [W-1:0] a_r, b_r;
        bus.start = 1'b0; bus.op = 3'd0; bus.rs = '0; bus.rt = '0; bus.flush = 1'b0;
        repeat (3) step();
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_dz", W'(bus.div_zero), '0);
        rst_n = 1'b1;
        step();

        // Moves back to back, then multiply/divide directed values.
        issue(OP_MTHI, 32'hDEADBEEF, 32'h0, lat);
        issue(OP_MTLO, 32'h12345678, 32'h0, lat);
        step();
        check("mthi_hold", bus.hi, 32'hDEADBEEF);
        check("mtlo_hold", bus.lo, 32'h12345678);
        run(OP_MULT,  32'hFFFFFFFE, 32'd3);
        run(OP_MULTU, 32'hFFFFFFFE, 32'd3);
        run(OP_DIV,   32'hFFFFFFF9, 32'd2);
        run(OP_DIVU,  32'd100, 32'd7);
        run(OP_DIV,   32'd5, 32'd0);
        issue(3'd6, 32'h1, 32'h2, lat);
        step();
        check("dz_sticky_reserved", W'(bus.div_zero), 32'd1);
        run(OP_MTLO, 32'hCAFEF00D, 32'h0);
        run(OP_DIV,  32'h80000000, 32'hFFFFFFFF);

        // Flush mid-divide: no write, no done.
        c = cyc;
        issue(OP_DIVU, 32'h0BADF00D, 32'd7, lat);
        wait_until(c + 10);
        bus.flush = 1'b1; busy_to = c + 10; abort();
        step();
        bus.flush = 1'b0;
        repeat (3) step();
        check("flush_hi", bus.hi, m_hi);
        check("flush_lo", bus.lo, m_lo);

        // Asynchronous reset mid-divide clears hi/lo at once.
        c = cyc;
        issue(OP_DIVU, 32'hFFFF0000, 32'd3, lat);
        wait_until(c + 10);
        rst_n = 1'b0;
        #1;
        check("arst_hi", bus.hi, '0);
        check("arst_lo", bus.lo, '0);
        check("arst_busy", W'(bus.busy), '0);
        abort();
        m_hi = '0; m_lo = '0; busy_from = 0; busy_to = -1;
        step();
        rst_n = 1'b1;
        step();

        // Flush on the final multiply edge.
        run(OP_MTHI, 32'h11111111, 32'h0);
        run(OP_MTLO, 32'h22222222, 32'h0);
        c = cyc;
        issue(OP_MULT, 32'h00001234, 32'h00005678, lat);
        wait_until(c + MC);
        bus.flush = 1'b1; abort();
        step();
        bus.flush = 1'b0;
        repeat (2) step();
        check("flush_last_hi", bus.hi, m_hi);
        check("flush_last_lo", bus.lo, m_lo);

        // Flush together with an MTHI accept.
        bus.start = 1'b1; bus.op = OP_MTHI; bus.rs = 32'hAAAA5555; bus.flush = 1'b1;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        step();
        check("flush_mthi_hi", bus.hi, m_hi);

        // Start while busy is ignored; MTLO in the divide's done cycle is taken.
        c = cyc;
        issue(OP_DIV, 32'hFFFFFF9C, 32'd9, lat);
        wait_until(c + 5);
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs = 32'h7; bus.rt = 32'h9;
        step();
        bus.start = 1'b0;
        wait_until(c + lat);
        run(OP_MTLO, 32'h5A5A5A5A, 32'h0);

        // Randomised ops, including reserved encodings and corner divisors.
        repeat (60) begin
            op_r = 3'($urandom_range(0, 7));
            a_r  = W'($urandom);
            b_r  = W'($urandom);
            if ($urandom_range(0, 3) == 0) b_r = '0;
            else if ($urandom_range(0, 4) == 0) b_r = W'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) begin
                a_r = 32'h80000000; b_r = '1;
            end
            run(op_r, a_r, b_r);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (5) step();
        check("scoreboard_empty", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: still running at cycle %0d, expected finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
